// File: rtl/float_to_fixed_sp.sv
// float_to_fixed_sp: 3-stage IEEE-754 single -> signed Q(31-F).F fixed-point converter, saturating.
// Build option: define FLOAT_TO_FIXED_ROUND_EN for round-to-nearest-even instead of truncation.
module float_to_fixed_sp #(
    parameter int unsigned p_FRAC_BITS = 0
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_FLOAT_WORD,
    input  logic        i_VALID,
    output logic        o_READY,
    output logic [31:0] o_FIXED_WORD,
    output logic        o_VALID,
    input  logic        i_READY,
    output logic        o_OVERFLOW,
    output logic        o_INVALID
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned SIG_W   = MANT_W + 1;
    localparam int unsigned SHIFT_W = 10;
    localparam int unsigned MAG_W   = WORD_W + 1;

    localparam logic [SHIFT_W-1:0] EXP_OFFSET      = SHIFT_W'(150);
    // Largest left shift that keeps every significand bit inside the 33-bit magnitude.
    localparam logic [SHIFT_W-1:0] MAX_LSHIFT      = SHIFT_W'(MAG_W - SIG_W);
    // Right shifts this large leave less than one half: result is zero in both builds.
    localparam logic [SHIFT_W-1:0] MIN_RSHIFT_ZERO = SHIFT_W'(SIG_W + 1);
    localparam logic [MAG_W-1:0]   POS_LIMIT       = MAG_W'(33'h0_7FFF_FFFF);
    localparam logic [MAG_W-1:0]   NEG_LIMIT       = MAG_W'(33'h0_8000_0000);
    localparam logic [WORD_W-1:0]  POS_SAT         = 32'h7FFF_FFFF;
    localparam logic [WORD_W-1:0]  NEG_SAT         = 32'h8000_0000;

    typedef struct packed {
        logic               sign;
        logic               nan;
        logic               inf;
        logic               zero;
        logic [SIG_W-1:0]   sig;
        logic [SHIFT_W-1:0] shift;
    } unpack_t;

    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             inf;
        logic             zero;
        logic             ovf;
        logic [MAG_W-1:0] mag;
    } align_t;

    logic              adv_c;
    logic [EXP_W-1:0]  in_exp_c;
    logic [MANT_W-1:0] in_mant_c;

    unpack_t s1_c;
    unpack_t s1_q;
    logic    s1_valid;

    align_t             s2_c;
    align_t             s2_q;
    logic               s2_valid;
    logic [SHIFT_W-1:0] rshift_c;

    logic [WORD_W-1:0] fix_c;
    logic              ovf_c;
    logic              inv_c;

`ifdef FLOAT_TO_FIXED_ROUND_EN
    logic [2*SIG_W-1:0] ext_c;
`endif

    // Whole pipeline moves as one; it only holds while the output is blocked.
    assign adv_c   = !o_VALID || i_READY;
    assign o_READY = !i_RST && adv_c;

    assign in_exp_c  = i_FLOAT_WORD[30:23];
    assign in_mant_c = i_FLOAT_WORD[22:0];

    // S1: unpack and classify.
    always_comb begin
        s1_c       = '0;
        s1_c.sign  = i_FLOAT_WORD[31];
        s1_c.nan   = (in_exp_c == '1) && (in_mant_c != '0);
        s1_c.inf   = (in_exp_c == '1) && (in_mant_c == '0);
        s1_c.zero  = (in_exp_c == '0);
        s1_c.sig   = {in_exp_c != '0, in_mant_c};
        s1_c.shift = SHIFT_W'(in_exp_c) - EXP_OFFSET + SHIFT_W'(p_FRAC_BITS);
    end

    // S2: align the significand to the fixed-point grid.
    always_comb begin
        s2_c      = '0;
        s2_c.sign = s1_q.sign;
        s2_c.nan  = s1_q.nan;
        s2_c.inf  = s1_q.inf;
        s2_c.zero = s1_q.zero;
        rshift_c  = SHIFT_W'(0) - s1_q.shift;
`ifdef FLOAT_TO_FIXED_ROUND_EN
        ext_c     = '0;
`endif
        if (!s1_q.shift[SHIFT_W-1]) begin
            if (s1_q.shift > MAX_LSHIFT) begin
                s2_c.ovf = (s1_q.sig != '0);
            end else begin
                s2_c.mag = MAG_W'(s1_q.sig) << s1_q.shift[3:0];
                s2_c.ovf = s2_c.mag[MAG_W-1];
            end
        end else if (rshift_c < MIN_RSHIFT_ZERO) begin
`ifdef FLOAT_TO_FIXED_ROUND_EN
            // Upper half is the kept magnitude, bit below it the guard, the rest sticky.
            ext_c    = {s1_q.sig, SIG_W'(0)} >> rshift_c[4:0];
            s2_c.mag = MAG_W'(ext_c[2*SIG_W-1:SIG_W]);
            if (ext_c[SIG_W-1] && ((|ext_c[SIG_W-2:0]) || ext_c[SIG_W])) begin
                s2_c.mag = s2_c.mag + MAG_W'(1);
            end
`else
            s2_c.mag = MAG_W'(s1_q.sig >> rshift_c[4:0]);
`endif
        end
    end

    // S3: apply sign and saturate; specials take priority.
    always_comb begin
        fix_c = '0;
        ovf_c = 1'b0;
        inv_c = 1'b0;
        if (s2_q.nan) begin
            inv_c = 1'b1;
        end else if (s2_q.inf || s2_q.ovf) begin
            ovf_c = 1'b1;
            fix_c = s2_q.sign ? NEG_SAT : POS_SAT;
        end else if (!s2_q.zero) begin
            if (!s2_q.sign) begin
                if (s2_q.mag > POS_LIMIT) begin
                    ovf_c = 1'b1;
                    fix_c = POS_SAT;
                end else begin
                    fix_c = s2_q.mag[WORD_W-1:0];
                end
            end else begin
                if (s2_q.mag > NEG_LIMIT) begin
                    ovf_c = 1'b1;
                    fix_c = NEG_SAT;
                end else begin
                    fix_c = ~s2_q.mag[WORD_W-1:0] + WORD_W'(1);
                end
            end
        end
    end

    // Pipeline registers; output word and flags are zero whenever no result is presented.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            s1_valid     <= 1'b0;
            s1_q         <= '0;
            s2_valid     <= 1'b0;
            s2_q         <= '0;
            o_VALID      <= 1'b0;
            o_FIXED_WORD <= '0;
            o_OVERFLOW   <= 1'b0;
            o_INVALID    <= 1'b0;
        end else if (adv_c) begin
            s1_valid     <= i_VALID;
            s1_q         <= s1_c;
            s2_valid     <= s1_valid;
            s2_q         <= s2_c;
            o_VALID      <= s2_valid;
            o_FIXED_WORD <= s2_valid ? fix_c : '0;
            o_OVERFLOW   <= s2_valid && ovf_c;
            o_INVALID    <= s2_valid && inv_c;
        end
    end

endmodule

// File: tb/tb_float_to_fixed_sp.sv
// Bench for float_to_fixed_sp: FRAC=0 and FRAC=16 instances share one input stream.
// Expected results are queued at input accept and popped at each output handshake.
module tb_float_to_fixed_sp;
    logic        clk = 1'b0;
    logic        rst;
    logic        vin;
    logic        rdy;
    logic [31:0] word;
    logic        ordy0, ordy16, ov0, ov16, ovf0, ovf16, inv0, inv16;
    logic [31:0] fix0, fix16;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] e0;
        logic [1:0]  f0;
        logic [31:0] e16;
        logic [1:0]  f16;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] dw[15];
    exp_t        de[15];
    logic [31:0] sw[4];
    logic [31:0] held;
    int          lat;
    bit          done;

`ifdef FLOAT_TO_FIXED_ROUND_EN
    localparam logic [31:0] R_3P5  = 32'd4;
    localparam logic [31:0] R_1P5  = 32'd2;
    localparam logic [31:0] R_M075 = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] R_3P5  = 32'd3;
    localparam logic [31:0] R_1P5  = 32'd1;
    localparam logic [31:0] R_M075 = 32'd0;
`endif

    always #5 clk = ~clk;

    float_to_fixed_sp #(.p_FRAC_BITS(0)) dut0 (
        .i_CLK(clk), .i_RST(rst), .i_FLOAT_WORD(word), .i_VALID(vin), .o_READY(ordy0),
        .o_FIXED_WORD(fix0), .o_VALID(ov0), .i_READY(rdy), .o_OVERFLOW(ovf0), .o_INVALID(inv0)
    );

    float_to_fixed_sp #(.p_FRAC_BITS(16)) dut16 (
        .i_CLK(clk), .i_RST(rst), .i_FLOAT_WORD(word), .i_VALID(vin), .o_READY(ordy16),
        .o_FIXED_WORD(fix16), .o_VALID(ov16), .i_READY(rdy), .o_OVERFLOW(ovf16), .o_INVALID(inv16)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Arithmetic reference: value = sig * 2^(exp-150+frac), then round/saturate. Result {fixed, ovf, inv}.
    function automatic logic [33:0] model(input logic [31:0] w, input int frac);
        logic [63:0] sig;
        logic [63:0] mag;
        logic [31:0] res;
        int          e;
        int          n;
        bit          big;
`ifdef FLOAT_TO_FIXED_ROUND_EN
        logic [63:0] rem;
        logic [63:0] half;
`endif
        big = 1'b0;
        mag = '0;
        if (w[30:23] == 8'hFF) begin
            if (w[22:0] != 23'd0) return {32'h0, 2'b01};
            return {(w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF), 2'b10};
        end
        if (w[30:23] == 8'h00) return '0;
        sig = {40'd0, 1'b1, w[22:0]};
        e = int'(w[30:23]) - 150 + frac;
        if (e >= 0) begin
            if (e > 39) big = 1'b1;
            else mag = sig << e;
        end else begin
            n = -e;
            if (n < 40) begin
                mag = sig >> n;
`ifdef FLOAT_TO_FIXED_ROUND_EN
                rem  = sig - (mag << n);
                half = 64'd1 << (n - 1);
                if (rem > half || (rem == half && mag[0])) mag = mag + 64'd1;
`endif
            end
        end
        if (!w[31]) begin
            if (big || mag > 64'h7FFF_FFFF) return {32'h7FFF_FFFF, 2'b10};
            return {mag[31:0], 2'b00};
        end
        if (big || mag > 64'h8000_0000) return {32'h8000_0000, 2'b10};
        res = ~mag[31:0] + 32'd1;
        return {res, 2'b00};
    endfunction

    function automatic exp_t mk(input logic [31:0] w);
        logic [33:0] a;
        logic [33:0] b;
        a = model(w, 0);
        b = model(w, 16);
        return exp_t'({a, b});
    endfunction

    function automatic exp_t dx(input logic [31:0] a0, input logic [1:0] g0,
                                input logic [31:0] a16, input logic [1:0] g16);
        return exp_t'({a0, g0, a16, g16});
    endfunction

    function automatic logic [31:0] rand_word();
        logic [7:0]  e;
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) e = 8'hFF;
        else if (sel == 1) e = 8'h00;
        else e = 8'($urandom_range(100, 165));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Offer one word until accepted (bounded), then queue its expectation.
    task automatic send(input logic [31:0] w, input exp_t e);
        bit acc;
        int waited;
        acc = 1'b0;
        waited = 0;
        word = w;
        vin = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = ordy0;
            @(posedge clk);
            #1;
            waited++;
        end
        vin = 1'b0;
        check1("accept_in_time", acc, 1'b1);
        if (acc) q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check32("drain_empty", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: both instances move in lockstep; every handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check1("valid_lockstep", ov16, ov0);
            check1("ready_lockstep", ordy16, ordy0);
            if (!ov0) check32("idle_flags", {30'd0, ovf0, inv0}, 32'd0);
            if (ov0 && rdy) begin
                check1("output_expected", 1'(q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    check32("fix_frac0", fix0, cur.e0);
                    check32("flags_frac0", {30'd0, ovf0, inv0}, {30'd0, cur.f0});
                    check32("fix_frac16", fix16, cur.e16);
                    check32("flags_frac16", {30'd0, ovf16, inv16}, {30'd0, cur.f16});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        vin  = 1'b0;
        rdy  = 1'b1;
        word = '0;
        done = 1'b0;

        dw[0]  = 32'h3F80_0000; de[0]  = dx(32'h0000_0001, 2'b00, 32'h0001_0000, 2'b00);
        dw[1]  = 32'h4060_0000; de[1]  = dx(R_3P5,         2'b00, 32'h0003_8000, 2'b00);
        dw[2]  = 32'hC020_0000; de[2]  = dx(32'hFFFF_FFFE, 2'b00, 32'hFFFD_8000, 2'b00);
        dw[3]  = 32'h4F00_0000; de[3]  = dx(32'h7FFF_FFFF, 2'b10, 32'h7FFF_FFFF, 2'b10);
        dw[4]  = 32'hCF00_0000; de[4]  = dx(32'h8000_0000, 2'b00, 32'h8000_0000, 2'b10);
        dw[5]  = 32'h7F80_0000; de[5]  = dx(32'h7FFF_FFFF, 2'b10, 32'h7FFF_FFFF, 2'b10);
        dw[6]  = 32'h7FC0_0000; de[6]  = dx(32'h0000_0000, 2'b01, 32'h0000_0000, 2'b01);
        dw[7]  = 32'h3FC0_0000; de[7]  = dx(R_1P5,         2'b00, 32'h0001_8000, 2'b00);
        dw[8]  = 32'h0000_0001; de[8]  = dx(32'h0000_0000, 2'b00, 32'h0000_0000, 2'b00);
        dw[9]  = 32'h8000_0000; de[9]  = dx(32'h0000_0000, 2'b00, 32'h0000_0000, 2'b00);
        dw[10] = 32'hFF80_0000; de[10] = dx(32'h8000_0000, 2'b10, 32'h8000_0000, 2'b10);
        dw[11] = 32'h4EFF_FFFF; de[11] = dx(32'h7FFF_FF80, 2'b00, 32'h7FFF_FFFF, 2'b10);
        dw[12] = 32'h3F00_0000; de[12] = dx(32'h0000_0000, 2'b00, 32'h0000_8000, 2'b00);
        dw[13] = 32'h4020_0000; de[13] = dx(32'h0000_0002, 2'b00, 32'h0002_8000, 2'b00);
        dw[14] = 32'hBF40_0000; de[14] = dx(R_M075,        2'b00, 32'hFFFF_4000, 2'b00);

        sw[0] = 32'h3F80_0000;
        sw[1] = 32'h4000_0000;
        sw[2] = 32'h4040_0000;
        sw[3] = 32'h4080_0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check1("reset_ready_low", ordy0, 1'b0);
        check1("reset_valid", ov0, 1'b0);
        check32("reset_fix", fix0, 32'd0);
        check1("reset_ovf", ovf0, 1'b0);
        check1("reset_inv", inv0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check1("ready_after_reset", ordy0, 1'b1);

        // Latency of a single word
        send(dw[0], de[0]);
        lat = 1;
        while (!ov0 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check32("latency", 32'(lat), 32'd3);
        drain();

        // Directed values, back to back
        for (int i = 0; i < 15; i++) send(dw[i], de[i]);
        drain();

        // Stream with a 5-cycle downstream stall mid-stream
        rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) send(sw[i], mk(sw[i]));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy = 1'b0;
                @(negedge clk);
                held = fix0;
                check1("stall_full_ready", ordy0, 1'b0);
                check32("stall_head", fix0, 32'd1);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check32("stall_stable", fix0, held);
                    check1("stall_valid", ov0, 1'b1);
                    check1("stall_ready", ordy0, 1'b0);
                end
                @(posedge clk);
                #1;
                rdy = 1'b1;
            end
        join
        drain();

        // Reset with three words in flight
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(sw[i], mk(sw[i]));
        check1("flush_full_ready", ordy0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check1("flush_reset_ready", ordy0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check1("flush_valid", ov0, 1'b0);
        check32("flush_fix", fix0, 32'd0);
        check32("flush_flags", {30'd0, ovf0, inv0}, 32'd0);
        rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check1("flush_no_output", ov0, 1'b0);
        end
        @(posedge clk);
        #1;
        send(dw[0], de[0]);
        drain();

        // Random words with random downstream backpressure
        fork
            begin
                logic [31:0] rw;
                for (int i = 0; i < 40; i++) begin
                    rw = rand_word();
                    send(rw, mk(rw));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rdy = 1'b1;
        drain();

        check32("queue_empty_end", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
